decode_stage: RTL

Pipelined, parametrised instruction-decode stage between fetch and execute. Accepts 32-bit instruction words over a valid/ready handshake and decodes the 7-bit opcode into the datapath control word (RW, DA, MD, BS, PS, MW, FS, MA, MB, AA, BA, CS) plus immediate. Registers the result in one output stage. Stalls on read-after-write hazards using an internal register scoreboard, and supports branch flush.

---
 rtl/decode_pkg.sv | 56 +++++
 rtl/decode_scoreboard.sv | 45 ++++
 rtl/decode_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Decode package: opcode values, control-word layout and the opcode decoder
// shared by decode_stage and its testbench-visible outputs.
package decode_pkg;

   localparam logic [6:0] OP_NOP = 7'h00;
   localparam logic [6:0] OP_ST  = 7'h01;
   localparam logic [6:0] OP_ADD = 7'h02;
   localparam logic [6:0] OP_SUB = 7'h05;
   localparam logic [6:0] OP_LD  = 7'h21;
   localparam logic [6:0] OP_ADI = 7'h42;
   localparam logic [6:0] OP_JMP = 7'h44;
   localparam logic [6:0] OP_BZ  = 7'h60;

   localparam int MD_W     = 2;
   localparam int BS_W     = 2;
   localparam int FS_PKG_W = 5;

   typedef struct packed {
      logic                rw;
      logic [MD_W-1:0]     md;
      logic [BS_W-1:0]     bs;
      logic                ps;
      logic                mw;
      logic [FS_PKG_W-1:0] fs;
      logic                ma;
      logic                mb;
      logic                cs;
   } ctrl_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  uses_a;
      logic  uses_b;
      logic  legal;
   } dec_t;

   // Unknown opcodes come back as an all-zero (NOP) control word with legal=0.
   function automatic dec_t decode_op(input logic [6:0] op);
      dec_t d;
      d       = '0;
      d.legal = 1'b1;
      case (op)
         OP_NOP: ;
         OP_ADD: begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'b00010; d.uses_a = 1'b1; d.uses_b = 1'b1; end
         OP_SUB: begin d.ctrl.rw = 1'b1; d.ctrl.fs = 5'b00101; d.uses_a = 1'b1; d.uses_b = 1'b1; end
         OP_LD:  begin d.ctrl.rw = 1'b1; d.ctrl.md = 2'b01; d.uses_a = 1'b1; end
         OP_ST:  begin d.ctrl.mw = 1'b1; d.uses_a = 1'b1; d.uses_b = 1'b1; end
         OP_ADI: begin d.ctrl.rw = 1'b1; d.ctrl.mb = 1'b1; d.ctrl.fs = 5'b00010; d.uses_a = 1'b1; end
         OP_BZ:  begin d.ctrl.bs = 2'b01; d.ctrl.mb = 1'b1; d.ctrl.cs = 1'b1; d.uses_a = 1'b1; end
         OP_JMP: begin d.ctrl.bs = 2'b11; d.uses_a = 1'b1; end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register scoreboard: one pending bit per register (R0 never tracked),
// with set, writeback clear, flush clear and a two-port hazard query.
module decode_scoreboard #(
   parameter int REG_ADDR_W = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic                  fclr_en,
   input  logic [REG_ADDR_W-1:0] fclr_addr,
   input  logic [REG_ADDR_W-1:0] rd_a,
   input  logic                  use_a,
   input  logic [REG_ADDR_W-1:0] rd_b,
   input  logic                  use_b,
   output logic                  busy_a,
   output logic                  busy_b
);
   import decode_pkg::*;

   localparam int NREG = 1 << REG_ADDR_W;

   logic [NREG-1:0] pending;

   // Per-register update; a set in the same cycle as a clear wins.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (set_en && set_addr == REG_ADDR_W'(i))
               pending[i] <= 1'b1;
            else if ((clr_en && clr_addr == REG_ADDR_W'(i)) ||
                     (fclr_en && fclr_addr == REG_ADDR_W'(i)))
               pending[i] <= 1'b0;
         end
      end
   end

   assign busy_a = use_a && pending[rd_a];
   assign busy_b = use_b && pending[rd_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: valid/ready input, one registered output stage,
// RAW-hazard stall via decode_scoreboard, branch flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN makes an unknown opcode a sticky trap
// that blocks further input until RESET.
module decode_stage #(
   parameter int REG_ADDR_W = 4,
   parameter int FS_W       = 5,
   parameter int IMM_W      = 15
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  in_valid,
   input  logic [31:0]           in_ir,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  RW,
   output logic [1:0]            MD,
   output logic [1:0]            BS,
   output logic                  PS,
   output logic                  MW,
   output logic [FS_W-1:0]       FS,
   output logic                  MA,
   output logic                  MB,
   output logic                  CS,
   output logic [REG_ADDR_W-1:0] DA,
   output logic [REG_ADDR_W-1:0] AA,
   output logic [REG_ADDR_W-1:0] BA,
   output logic [IMM_W-1:0]      imm,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                  flush,
   output logic                  illegal
);
   import decode_pkg::*;

   // ---- stage p0: field slicing, decode, hazard and handshake ----
   dec_t                  dec;
   logic [REG_ADDR_W-1:0] in_da, in_aa, in_ba;
   logic                  busy_a, busy_b, hazard, accept, trap_blk;

   ctrl_t                 ctrl_p1;
   logic [REG_ADDR_W-1:0] da_p1, aa_p1, ba_p1;
   logic [IMM_W-1:0]      imm_p1;
   logic                  vld_p1;

   assign dec   = decode_op(in_ir[31:25]);
   assign in_da = in_ir[20+REG_ADDR_W-1:20];
   assign in_aa = in_ir[15+REG_ADDR_W-1:15];
   assign in_ba = in_ir[10+REG_ADDR_W-1:10];

   decode_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
      .CLK       (CLK),
      .RESET     (RESET),
      .set_en    (accept && dec.ctrl.rw),
      .set_addr  (in_da),
      .clr_en    (wb_valid),
      .clr_addr  (wb_addr),
      .fclr_en   (flush && vld_p1 && ctrl_p1.rw),
      .fclr_addr (da_p1),
      .rd_a      (in_aa),
      .use_a     (dec.uses_a),
      .rd_b      (in_ba),
      .use_b     (dec.uses_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b)
   );

   // A writeback in the same cycle does not release a stalled reader.
   assign hazard   = in_valid && (busy_a || busy_b);
   assign in_ready = !flush && !hazard && (!vld_p1 || out_ready) && !trap_blk;
   assign accept   = in_valid && in_ready;

   // ---- stage p1: registered control word ----
   // Load on accept; flush kills the held word; hold while execute stalls.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_p1  <= 1'b0;
         ctrl_p1 <= '0;
         da_p1   <= '0;
         aa_p1   <= '0;
         ba_p1   <= '0;
         imm_p1  <= '0;
      end else if (flush) begin
         vld_p1  <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         ctrl_p1 <= dec.ctrl;
         da_p1   <= in_da;
         aa_p1   <= in_aa;
         ba_p1   <= in_ba;
         imm_p1  <= in_ir[IMM_W-1:0];
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic illegal_p1;

   // Sticky trap once an unknown opcode has been accepted.
   always_ff @(posedge CLK) begin
      if (RESET)
         illegal_p1 <= 1'b0;
      else if (accept && !dec.legal)
         illegal_p1 <= 1'b1;
   end

   assign illegal  = illegal_p1;
   assign trap_blk = illegal_p1;
`else
   assign illegal  = 1'b0;
   assign trap_blk = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{in_ir, dec.legal};

   assign out_valid = vld_p1;
   assign RW  = ctrl_p1.rw;
   assign MD  = ctrl_p1.md;
   assign BS  = ctrl_p1.bs;
   assign PS  = ctrl_p1.ps;
   assign MW  = ctrl_p1.mw;
   assign FS  = FS_W'(ctrl_p1.fs);
   assign MA  = ctrl_p1.ma;
   assign MB  = ctrl_p1.mb;
   assign CS  = ctrl_p1.cs;
   assign DA  = da_p1;
   assign AA  = aa_p1;
   assign BA  = ba_p1;
   assign imm = imm_p1;

endmodule
